rtc_lector: RTL and testbench
=============================

# rtc_lector

Reads the current hour, day, month and year from the external RTC over its 8-bit multiplexed address/data bus and presents them as stable BCD bytes on `fechah`, `fechad`, `fecham` and `fechaa`. It sits directly upstream of the on-screen date/time overlay renderer, which consumes those four bytes asynchronously to the refresh sweep. All four values are committed together, so the display never shows a half-updated date.

## Interface
- `TPH`, 4: strobe width in clk cycles for both `wr_n` and `rd_n` pulses; must be ≥1.
- `PERIOD`, 1000000: clk cycles between refresh ticks; must exceed 4·(2·TPH+5)+1.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  permits new sweeps; a sweep in progress always completes.
- `bus_in`  in  8  RTC data bus, sampled during reads.
- `bus_out`  out  8  address byte driven to the RTC.
- `bus_oe`  out  1  top-level tristate enable for `bus_out`.
- `cs_n`, `rd_n`, `wr_n`  out  1 each  RTC strobes, active low.
- `ad`  out  1  0 = address phase, 1 = data phase.
- `fechah`, `fechad`, `fecham`, `fechaa`  out  8 each  BCD hour, day, month, year.
- `valid`  out  1  one-cycle pulse on a successful commit.
- `err`  out  1  one-cycle pulse when a sweep is discarded.
- `busy`  out  1  high from sweep start through commit/discard.

## Operation
- Reset values: `cs_n`=`rd_n`=`wr_n`=1, `ad`=0, `bus_oe`=0, `bus_out`=0x00, `fechah`=0x00, `fechad`=0x01, `fecham`=0x01, `fechaa`=0x00, `valid`=`err`=`busy`=0. The pending flag resets to 1.
- Tick counter: free-running from reset, counts modulo PERIOD. Each wrap sets pending.
- A sweep starts when the FSM is in IDLE, pending=1 and `en`=1. Starting a sweep clears pending.
- A tick that arrives while busy, or while `en`=0, stays pending. Multiple ticks collapse into one.
- Sweep reads registers in this order: 0x23 hour, 0x24 day, 0x25 month, 0x26 year. Bytes go into shadow registers.
- FSM states per access:
  - A_SET (1 cycle): `cs_n`=0, `ad`=0, `bus_oe`=1, `bus_out`=addr.
  - A_STB (TPH cycles): as A_SET, plus `wr_n`=0.
  - A_HLD (1 cycle): `wr_n`=1, still driving.
  - GAP (1 cycle): `cs_n`=1, `bus_oe`=0.
  - D_SET (1 cycle): `cs_n`=0, `ad`=1.
  - D_STB (TPH cycles): `rd_n`=0; `bus_in` is captured on the edge that leaves D_STB.
  - D_HLD (1 cycle): `rd_n`=1.
- After D_HLD: go to the next address, or evaluate if the year has been read.
- Each access takes 2·TPH+5 cycles. The sweep returns `cs_n`=1, `ad`=0 after the final D_HLD.
- Evaluate step: if every shadow nibble is ≤9, all four outputs update on the same edge and `valid` pulses. Otherwise outputs hold their values and `err` pulses. No range checking beyond BCD digit validity is performed.
- Invariant: `bus_oe`=1 never coincides with `rd_n`=0.
- Invariant: `wr_n`=0 and `rd_n`=0 are never both asserted, and neither is asserted while `cs_n`=1.
- `rst` asserted at any point forces all reset values immediately. A partial sweep is lost and its shadows are not committed. After release, pending=1, so a fresh sweep begins.

## Timing
- All outputs are registered; no combinational path from `bus_in` or `en` to any output.
- First sweep: `cs_n` falls on the first rising edge with `rst`=1 and `en`=1.
- `valid`/`err` and the output update occur 4·(2·TPH+5) cycles after `cs_n` first falls (52 cycles at TPH=4). Each pulse lasts 1 cycle.
- `busy` rises on the same edge `cs_n` first falls. It falls on the edge after the `valid`/`err` pulse.
- With `en`=1 continuously, sweeps start every PERIOD cycles, aligned to counter wraps (after the initial reset sweep).
- `en` falling mid-sweep has no effect on that sweep.

## Test plan
- Reset release, `en`=1, TPH=4; RTC model returns 0x23→0x14, 0x24→0x06, 0x25→0x04, 0x26→0x17 -> `valid` pulses 52 cycles after `cs_n` first falls; outputs become h=0x14, d=0x06, m=0x04, a=0x17; `busy` spans 53 cycles.
- Same sweep, bus monitor -> addresses 0x23..0x26 driven in order; `wr_n` and `rd_n` each low exactly 4 cycles per access; `bus_oe`=0 whenever `rd_n`=0; `cs_n` high for exactly 1 cycle between address and data phases.
- Month returns 0x1A after a good sweep -> `err` pulses at cycle 52, no `valid`, outputs stay 0x14/0x06/0x04/0x17.
- PERIOD=100, `en`=0 across two wraps, then `en`=1 -> exactly one sweep starts on the next edge, then subsequent sweeps start 100 cycles apart.
- `rst` asserted during D_STB of the month read -> immediately `cs_n`=`rd_n`=1, `bus_oe`=0, outputs 0x00/0x01/0x01/0x00; after release, a new sweep restarts at address 0x23.
- TPH=1 with the data from scenario 1 -> commit at 4·7=28 cycles with identical values.

Source files
------------

// File: rtl/rtc_lector.sv
// RTC date/time reader: periodically sweeps hour/day/month/year over the RTC's
// multiplexed bus and commits all four BCD bytes atomically when they are valid.
module rtc_lector #(
  parameter int TPH    = 4,
  parameter int PERIOD = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad,
  output logic [7:0] fechah,
  output logic [7:0] fechad,
  output logic [7:0] fecham,
  output logic [7:0] fechaa,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SW = $clog2(TPH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);
  localparam logic [SW-1:0] STB_MAX = SW'(TPH - 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_A_SET = 4'd1;
  localparam logic [3:0] S_A_STB = 4'd2;
  localparam logic [3:0] S_A_HLD = 4'd3;
  localparam logic [3:0] S_GAP   = 4'd4;
  localparam logic [3:0] S_D_SET = 4'd5;
  localparam logic [3:0] S_D_STB = 4'd6;
  localparam logic [3:0] S_D_HLD = 4'd7;
  localparam logic [3:0] S_EVAL  = 4'd8;

  localparam logic [31:0] FECHA_RST = {8'h00, 8'h01, 8'h01, 8'h00};

  logic [3:0]      state_q, state_d;
  logic [SW-1:0]   stb_q, stb_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic [3:0][7:0] sh_q, sh_d;
  logic [3:0][7:0] fecha_q, fecha_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            cs_n_q, cs_n_d;
  logic            rd_n_q, rd_n_d;
  logic            wr_n_q, wr_n_d;
  logic            ad_q, ad_d;
  logic            bus_oe_q, bus_oe_d;
  logic [7:0]      bus_out_q, bus_out_d;

  logic wrap;
  logic start;
  logic stb_done;
  logic [7:0] addr_d;

  function automatic logic all_bcd(input logic [31:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign wrap     = (cnt_q == CNT_MAX);
  assign start    = (state_q == S_IDLE) && pending_q && en;
  assign stb_done = (stb_q == STB_MAX);

  // Tick counter and pending flag; a wrap always wins so no tick is ever lost.
  always_comb begin
    cnt_d     = wrap ? '0 : cnt_q + CW'(1);
    pending_d = pending_q;
    if (start) pending_d = 1'b0;
    if (wrap)  pending_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    fecha_d = fecha_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_A_SET;
          idx_d   = 2'd0;
        end
      end
      S_A_SET: begin
        state_d = S_A_STB;
        stb_d   = '0;
      end
      S_A_STB: begin
        if (stb_done) begin
          state_d = S_A_HLD;
          stb_d   = '0;
        end else begin
          stb_d = stb_q + SW'(1);
        end
      end
      S_A_HLD: state_d = S_GAP;
      S_GAP:   state_d = S_D_SET;
      S_D_SET: begin
        state_d = S_D_STB;
        stb_d   = '0;
      end
      S_D_STB: begin
        if (stb_done) begin
          sh_d[idx_q] = bus_in;
          state_d     = S_D_HLD;
          stb_d       = '0;
        end else begin
          stb_d = stb_q + SW'(1);
        end
      end
      S_D_HLD: begin
        if (idx_q == 2'd3) begin
          state_d = S_EVAL;
          // Commit all four bytes together, or none of them.
          if (all_bcd(sh_q)) begin
            fecha_d = sh_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_A_SET;
        end
      end
      S_EVAL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus pins are decoded from the next state so they leave the flops glitch-free.
  assign addr_d = 8'h23 + {6'd0, idx_d};

  always_comb begin
    cs_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    ad_d      = 1'b0;
    bus_oe_d  = 1'b0;
    bus_out_d = 8'h00;
    case (state_d)
      S_A_SET, S_A_HLD: begin
        cs_n_d    = 1'b0;
        bus_oe_d  = 1'b1;
        bus_out_d = addr_d;
      end
      S_A_STB: begin
        cs_n_d    = 1'b0;
        bus_oe_d  = 1'b1;
        bus_out_d = addr_d;
        wr_n_d    = 1'b0;
      end
      S_D_SET, S_D_HLD: begin
        cs_n_d = 1'b0;
        ad_d   = 1'b1;
      end
      S_D_STB: begin
        cs_n_d = 1'b0;
        ad_d   = 1'b1;
        rd_n_d = 1'b0;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      stb_q     <= '0;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      pending_q <= 1'b1;
      sh_q      <= '0;
      fecha_q   <= FECHA_RST;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ad_q      <= 1'b0;
      bus_oe_q  <= 1'b0;
      bus_out_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      stb_q     <= stb_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      sh_q      <= sh_d;
      fecha_q   <= fecha_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      ad_q      <= ad_d;
      bus_oe_q  <= bus_oe_d;
      bus_out_q <= bus_out_d;
    end
  end

  assign fechah  = fecha_q[0];
  assign fechad  = fecha_q[1];
  assign fecham  = fecha_q[2];
  assign fechaa  = fecha_q[3];
  assign valid   = valid_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign cs_n    = cs_n_q;
  assign rd_n    = rd_n_q;
  assign wr_n    = wr_n_q;
  assign ad      = ad_q;
  assign bus_oe  = bus_oe_q;
  assign bus_out = bus_out_q;

endmodule

// File: tb/tb_rtc_lector.sv
// Bench for rtc_lector: an RTC memory model answers the bus, and each sweep is
// checked for protocol shape, commit timing and committed values.
`timescale 1ns/1ps
module tb_rtc_lector;

  localparam int P4 = 100;
  localparam int P1 = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst4, en4, rst1, en1;
  logic [7:0] bus_in;

  logic [7:0] bo4, h4, d4, m4, a4, bo1, h1, d1, m1, a1;
  logic oe4, cs4, rd4, wr4, ad4, v4, e4, b4;
  logic oe1, cs1, rd1, wr1, ad1, v1, e1, b1;

  rtc_lector #(.TPH(4), .PERIOD(P4)) u_dut4 (
    .clk(clk), .rst(rst4), .en(en4), .bus_in(bus_in), .bus_out(bo4), .bus_oe(oe4),
    .cs_n(cs4), .rd_n(rd4), .wr_n(wr4), .ad(ad4), .fechah(h4), .fechad(d4),
    .fecham(m4), .fechaa(a4), .valid(v4), .err(e4), .busy(b4));

  rtc_lector #(.TPH(1), .PERIOD(P1)) u_dut1 (
    .clk(clk), .rst(rst1), .en(en1), .bus_in(bus_in), .bus_out(bo1), .bus_oe(oe1),
    .cs_n(cs1), .rd_n(rd1), .wr_n(wr1), .ad(ad1), .fechah(h1), .fechad(d1),
    .fecham(m1), .fechaa(a1), .valid(v1), .err(e1), .busy(b1));

  // sel picks which instance is monitored and served by the RTC model
  logic sel = 1'b0;
  logic [7:0] m_bo, m_h, m_d, m_m, m_a;
  logic m_oe, m_cs, m_rd, m_wr, m_ad, m_v, m_e, m_b;
  assign m_bo = sel ? bo1 : bo4;
  assign m_h  = sel ? h1 : h4;
  assign m_d  = sel ? d1 : d4;
  assign m_m  = sel ? m1 : m4;
  assign m_a  = sel ? a1 : a4;
  assign m_oe = sel ? oe1 : oe4;
  assign m_cs = sel ? cs1 : cs4;
  assign m_rd = sel ? rd1 : rd4;
  assign m_wr = sel ? wr1 : wr4;
  assign m_ad = sel ? ad1 : ad4;
  assign m_v  = sel ? v1 : v4;
  assign m_e  = sel ? e1 : e4;
  assign m_b  = sel ? b1 : b4;

  // ---------------- RTC model ----------------
  logic [7:0] rtc_mem [256];
  logic [7:0] lat_addr = 8'h00;
  always @(posedge clk) if (!m_cs && !m_wr && m_oe) lat_addr <= m_bo;
  assign bus_in = rtc_mem[lat_addr];

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_f [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bcd(input logic [7:0] b);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9);
  endfunction

  function automatic logic [7:0] rand_byte();
    if ($urandom_range(0, 4) == 0) return 8'($urandom_range(0, 255));
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_mem(input logic [7:0] h, input logic [7:0] d, input logic [7:0] m,
                         input logic [7:0] a);
    rtc_mem[8'h23] = h;
    rtc_mem[8'h24] = d;
    rtc_mem[8'h25] = m;
    rtc_mem[8'h26] = a;
  endtask

  task automatic set_mem_random();
    set_mem(rand_byte(), rand_byte(), rand_byte(), rand_byte());
  endtask

  task automatic reset_model();
    exp_f = '{8'h00, 8'h01, 8'h01, 8'h00};
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_h"}, m_h, exp_f[0]);
    chk({tag, "_d"}, m_d, exp_f[1]);
    chk({tag, "_m"}, m_m, exp_f[2]);
    chk({tag, "_a"}, m_a, exp_f[3]);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cs_n"}, m_cs, 1);
    chk({tag, "_rd_n"}, m_rd, 1);
    chk({tag, "_wr_n"}, m_wr, 1);
    chk({tag, "_ad"}, m_ad, 0);
    chk({tag, "_oe"}, m_oe, 0);
    chk({tag, "_bus_out"}, m_bo, 0);
    chk({tag, "_valid"}, m_v, 0);
    chk({tag, "_err"}, m_e, 0);
    chk({tag, "_busy"}, m_b, 0);
    check_outputs(tag);
  endtask

  // Waits for the next sweep, follows it to completion and checks it against
  // the RTC contents as they stand when the sweep begins.
  task automatic do_sweep(input int tph, input bit drop_en, output int waited,
                          output int start_cyc);
    int n, vk, ek, nv, ne, busy_n, csh, viol;
    int wr_lo[4];
    int rd_lo[4];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] snap[4];
    logic [7:0] g;
    bit ok;
    logic prev_wr;
    n = 2 * tph + 5;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      snap[i] = rtc_mem[8'h23 + i];
      exp_q.push_back(8'(8'h23 + i));
      if (!is_bcd(snap[i])) ok = 1'b0;
      wr_lo[i] = 0;
      rd_lo[i] = 0;
    end
    waited = 0;
    start_cyc = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (m_cs && waited < 400);
    chk("sweep_start", m_cs, 0);
    if (m_cs) return;
    start_cyc = cyc;
    vk = -1; ek = -1; nv = 0; ne = 0; busy_n = 0; csh = 0; viol = 0;
    prev_wr = 1'b1;
    for (int k = 0; k <= 4 * n + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (drop_en && k == 10) begin
        if (sel) en1 = 1'b0; else en4 = 1'b0;
      end
      if (m_oe && !m_rd) viol++;
      if (!m_wr && !m_rd) viol++;
      if (m_cs && (!m_wr || !m_rd)) viol++;
      if (k < 4 * n) begin
        if (!m_wr) wr_lo[k / n]++;
        if (!m_rd) rd_lo[k / n]++;
        if (m_cs) csh++;
      end
      if (!m_wr && prev_wr) got_q.push_back(m_bo);
      prev_wr = m_wr;
      if (m_v) begin nv++; vk = k; end
      if (m_e) begin ne++; ek = k; end
      if (m_b) busy_n++;
    end
    chk("addr_count", got_q.size(), 4);
    while (exp_q.size() > 0) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'h00;
      chk("addr_order", g, exp_q.pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      chk("wr_n_low_width", wr_lo[i], tph);
      chk("rd_n_low_width", rd_lo[i], tph);
    end
    chk("cs_n_gap_cycles", csh, 4);
    chk("strobe_invariants", viol, 0);
    chk("valid_cycle", vk, ok ? 4 * n : -1);
    chk("err_cycle", ek, ok ? -1 : 4 * n);
    chk("valid_pulses", nv, ok ? 1 : 0);
    chk("err_pulses", ne, ok ? 0 : 1);
    chk("busy_cycles", busy_n, 4 * n + 1);
    if (ok) for (int i = 0; i < 4; i++) exp_f[i] = snap[i];
    check_outputs("commit");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w, s, s3, s4, lo;
    for (int i = 0; i < 256; i++) rtc_mem[i] = 8'h00;
    rst4 = 1'b0; en4 = 1'b1;
    rst1 = 1'b0; en1 = 1'b0;
    sel = 1'b0;
    reset_model();
    set_mem(8'h14, 8'h06, 8'h04, 8'h17);
    repeat (3) @(negedge clk);
    check_reset_vals("rst4");

    rst4 = 1'b1;
    do_sweep(4, 1'b0, w, s);
    chk("first_start_wait", w, 1);
    chk("first_h", m_h, 8'h14);

    set_mem(8'h14, 8'h06, 8'h1A, 8'h17);
    do_sweep(4, 1'b0, w, s);
    chk("bad_month_hold_m", m_m, 8'h04);

    for (int i = 0; i < 6; i++) begin
      set_mem_random();
      do_sweep(4, (i == 2), w, s);
      en4 = 1'b1;
    end

    // Ticks while disabled collapse into a single sweep on re-enable.
    en4 = 1'b0;
    lo = 0;
    repeat (250) begin
      @(negedge clk);
      if (!m_cs) lo++;
    end
    chk("en_low_no_sweep", lo, 0);
    en4 = 1'b1;
    set_mem_random();
    do_sweep(4, 1'b0, w, s);
    chk("en_resume_wait", w, 1);
    set_mem_random();
    do_sweep(4, 1'b0, w, s);
    set_mem_random();
    do_sweep(4, 1'b0, w, s3);
    set_mem_random();
    do_sweep(4, 1'b0, w, s4);
    chk("period_spacing", s4 - s3, P4);

    // Reset in the middle of the month read's data strobe.
    set_mem(8'h09, 8'h28, 8'h02, 8'h99);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (m_cs && w < 400);
    chk("rst_sweep_start", m_cs, 0);
    repeat (35) @(negedge clk);
    chk("mid_month_rd_n", m_rd, 0);
    chk("mid_month_addr", lat_addr, 8'h25);
    rst4 = 1'b0;
    #1;
    reset_model();
    check_reset_vals("rst_mid");
    repeat (2) @(negedge clk);
    rst4 = 1'b1;
    set_mem(8'h23, 8'h31, 8'h12, 8'h05);
    do_sweep(4, 1'b0, w, s);
    chk("post_rst_wait", w, 1);

    // Minimum strobe width instance.
    @(negedge clk);
    en4 = 1'b0;
    sel = 1'b1;
    en1 = 1'b1;
    reset_model();
    set_mem(8'h14, 8'h06, 8'h04, 8'h17);
    @(negedge clk);
    check_reset_vals("rst1");
    rst1 = 1'b1;
    do_sweep(1, 1'b0, w, s);
    chk("tph1_start_wait", w, 1);
    for (int i = 0; i < 3; i++) begin
      set_mem_random();
      do_sweep(1, 1'b0, w, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
